ln_stat_accum: RTL and testbench
================================

// Module: ln_stat_accum
// PURPOSE
//   Layernorm statistics stage that sits directly downstream of the layernorm
//   input fifo. It pops exactly VEC_LEN signed elements per vector and
//   accumulates their sum and sum of squares, then hands both results to the
//   mean/variance stage through a valid/ready handshake.
// PARAMETERS
//   WIDTH    8   element width, signed two's complement (matches fifo WIDTH)
//   VEC_LEN  64  elements per vector, >=2; CW = $clog2(VEC_LEN+1)
// PORTS
//   clk         in   1                 clock
//   rstn        in   1                 async active-low reset
//   start       in   1                 pulse: begin one vector (IDLE only)
//   fifo_empty  in   1                 fifo empty flag
//   fifo_dout   in   WIDTH             fifo read data (valid cycle after rd_en)
//   fifo_rd_en  out  1                 fifo read enable
//   busy        out  1                 high in RUN and DONE
//   out_valid   out  1                 results valid
//   out_ready   in   1                 consumer accepts results
//   sum_out     out  WIDTH+CW          signed sum of elements
//   sumsq_out   out  2*WIDTH+CW        unsigned sum of squares
//   absmax_out  out  WIDTH             max |x|, only with LN_STAT_ABSMAX_EN
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, counters=0, rd_pend=0, all
//     accumulators=0, fifo_rd_en=0, busy=0, out_valid=0, sum_out=0,
//     sumsq_out=0, absmax_out=0.
//   - FSM IDLE -> RUN on start. RUN -> DONE when accumulated count reaches
//     VEC_LEN. DONE -> IDLE when out_valid & out_ready.
//   - start outside IDLE is ignored. On IDLE -> RUN, the accumulators and the
//     issue/accum counters clear to 0.
//   - fifo_rd_en = (state==RUN) & !fifo_empty & (issued < VEC_LEN). It is
//     combinational. issued increments on every rd_en cycle.
//   - rd_pend is rd_en registered. When rd_pend=1, fifo_dout is sign-extended
//     and added to sum. fifo_dout*fifo_dout (signed product, non-negative) is
//     added to sumsq. accum increments. fifo_dout is ignored when rd_pend=0
//     (the fifo drives 0 there).
//   - Widths are sized so that no overflow is possible for VEC_LEN elements.
//     No saturation and no rounding.
//   - Empty stalls: rd_en drops and accumulation pauses. There is no timeout.
//   - Latency with the fifo never empty: start sampled at edge 0; rd_en high
//     in cycles 1..VEC_LEN; out_valid high from cycle VEC_LEN+2.
//   - sum_out, sumsq_out and absmax_out are registered. They load on entry to
//     DONE and hold stable while out_valid=1 & !out_ready.
//   - out_valid is high only in DONE. It deasserts the cycle after the
//     handshake. The outputs keep their last value in IDLE.
//   - The block never issues more than VEC_LEN reads per vector. Extra fifo
//     data stays in the fifo for the next vector.
// CONFIGURATION
//   LN_STAT_ABSMAX_EN defined:
//     - absmax_out port exists.
//     - A running max of |x| is kept, cleared on start.
//     - |-2^(WIDTH-1)| is reported as 2^(WIDTH-1), stored unsigned in WIDTH
//       bits.
//     - absmax_out loads with the other results in DONE.
//   LN_STAT_ABSMAX_EN undefined: no absmax_out port and no max logic.
//     All other behaviour is identical.
// TESTING (WIDTH=8, VEC_LEN=4 unless noted)
//   1. fifo preloaded with 1,2,3,4; start -> rd_en cycles 1-4; out_valid at
//      cycle 6; sum=10, sumsq=30, absmax=4.
//   2. Data -3,-3,-3,-3 -> sum=-12, sumsq=36. Data -128 x4 -> sum=-512,
//      sumsq=65536, absmax=128.
//   3. fifo empty for 5 cycles after the 2nd pop, then refilled -> rd_en
//      low while empty, no spurious accumulation; sum matches the data.
//   4. out_ready low for 10 cycles in DONE -> outputs stable. start pulses
//      there are ignored. Handshake -> IDLE next cycle.
//   5. rstn asserted mid-RUN after 2 pops -> all outputs 0 at once. A new
//      start after release accumulates only the new vector.
//   6. 6 elements in fifo, two back-to-back vectors -> the first uses exactly
//      4 pops; the second consumes the remaining 2 plus 2 later writes.

Source files
------------

// File: rtl/ln_stat_accum.sv
// ln_stat_accum: layernorm statistics stage. Pops VEC_LEN signed elements from
// the upstream fifo and accumulates sum and sum of squares, then presents them
// through a valid/ready handshake.
// Optional feature: define LN_STAT_ABSMAX_EN to add absmax_out (running max |x|).
module ln_stat_accum #(
  parameter int  WIDTH   = 8,
  parameter int  VEC_LEN = 64,
  localparam int CW      = $clog2(VEC_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        fifo_empty,
  input  logic [WIDTH-1:0]            fifo_dout,
  output logic                        fifo_rd_en,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH+CW-1:0]  sum_out,
  output logic [2*WIDTH+CW-1:0]       sumsq_out
`ifdef LN_STAT_ABSMAX_EN
  ,
  output logic [WIDTH-1:0]            absmax_out
`endif
);

  localparam int            SW        = WIDTH + CW;
  localparam int            QW        = 2 * WIDTH + CW;
  localparam logic [CW-1:0] VEC_LEN_C = CW'(VEC_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          issued_q, issued_d;
  logic [CW-1:0]          accum_q, accum_d;
  logic                   rd_pend_q, rd_pend_d;
  logic signed [SW-1:0]   sum_q, sum_d;
  logic signed [SW-1:0]   sum_out_q, sum_out_d;
  logic [QW-1:0]          sumsq_q, sumsq_d;
  logic [QW-1:0]          sumsq_out_q, sumsq_out_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic                   rd_en;
  logic signed [WIDTH-1:0]   x;
  logic signed [2*WIDTH-1:0] x_sq;
`ifdef LN_STAT_ABSMAX_EN
  logic [WIDTH-1:0]       x_abs;
  logic [WIDTH-1:0]       absmax_q, absmax_d;
  logic [WIDTH-1:0]       absmax_out_q, absmax_out_d;
`endif

  // Element datapath: sign view, square and magnitude of the popped word.
  always_comb begin
    x    = signed'(fifo_dout);
    x_sq = (2*WIDTH)'(x) * (2*WIDTH)'(x);
`ifdef LN_STAT_ABSMAX_EN
    // Two's complement negate in WIDTH bits maps -2^(WIDTH-1) to 2^(WIDTH-1) unsigned.
    x_abs = fifo_dout[WIDTH-1] ? (~fifo_dout + WIDTH'(1)) : fifo_dout;
`endif
  end

  // Read issue: never more than VEC_LEN reads per vector, stall while empty.
  always_comb begin
    rd_en = (state_q == S_RUN) && !fifo_empty && (issued_q < VEC_LEN_C);
  end

  // Next-state, counters, accumulators and registered result outputs.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    accum_d     = accum_q;
    rd_pend_d   = rd_en;
    sum_d       = sum_q;
    sumsq_d     = sumsq_q;
    sum_out_d   = sum_out_q;
    sumsq_out_d = sumsq_out_q;
`ifdef LN_STAT_ABSMAX_EN
    absmax_d     = absmax_q;
    absmax_out_d = absmax_out_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          issued_d = '0;
          accum_d  = '0;
          sum_d    = '0;
          sumsq_d  = '0;
`ifdef LN_STAT_ABSMAX_EN
          absmax_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (rd_en) begin
          issued_d = issued_q + CW'(1);
        end
        // Data returns one cycle after the read; the last return both
        // accumulates and loads the output registers on the same edge.
        if (rd_pend_q) begin
          sum_d   = sum_q + SW'(x);
          sumsq_d = sumsq_q + QW'($unsigned(x_sq));
          accum_d = accum_q + CW'(1);
`ifdef LN_STAT_ABSMAX_EN
          absmax_d = (x_abs > absmax_q) ? x_abs : absmax_q;
`endif
          if (accum_q == VEC_LEN_C - CW'(1)) begin
            state_d     = S_DONE;
            sum_out_d   = sum_d;
            sumsq_out_d = sumsq_d;
`ifdef LN_STAT_ABSMAX_EN
            absmax_out_d = absmax_d;
`endif
          end
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and result registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      issued_q    <= '0;
      accum_q     <= '0;
      rd_pend_q   <= 1'b0;
      sum_q       <= '0;
      sumsq_q     <= '0;
      sum_out_q   <= '0;
      sumsq_out_q <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef LN_STAT_ABSMAX_EN
      absmax_q     <= '0;
      absmax_out_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      accum_q     <= accum_d;
      rd_pend_q   <= rd_pend_d;
      sum_q       <= sum_d;
      sumsq_q     <= sumsq_d;
      sum_out_q   <= sum_out_d;
      sumsq_out_q <= sumsq_out_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
`ifdef LN_STAT_ABSMAX_EN
      absmax_q     <= absmax_d;
      absmax_out_q <= absmax_out_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign sum_out    = sum_out_q;
  assign sumsq_out  = sumsq_out_q;
`ifdef LN_STAT_ABSMAX_EN
  assign absmax_out = absmax_out_q;
`endif

endmodule

// File: tb/tb_ln_stat_accum.sv
// tb_ln_stat_accum: randomized bench for ln_stat_accum with a queue-based fifo
// model and a reference that derives each vector's results from the push log.
module tb_ln_stat_accum;

  localparam int WIDTH   = 8;
  localparam int VEC_LEN = 4;
  localparam int CW      = $clog2(VEC_LEN + 1);

  logic                       clk        = 1'b0;
  logic                       rstn       = 1'b0;
  logic                       start      = 1'b0;
  logic                       out_ready  = 1'b0;
  logic                       fifo_empty = 1'b1;
  logic [WIDTH-1:0]           fifo_dout  = '0;
  logic                       fifo_rd_en;
  logic                       busy;
  logic                       out_valid;
  logic signed [WIDTH+CW-1:0] sum_out;
  logic [2*WIDTH+CW-1:0]      sumsq_out;
`ifdef LN_STAT_ABSMAX_EN
  logic [WIDTH-1:0]           absmax_out;
`endif

  int tests = 0;
  int fails = 0;
  int pushed[$];    // every value ever written to the fifo, in order
  int push_req[$];  // writes waiting for the next clock edge
  int fq[$];        // fifo contents
  int pop_count = 0;

  always #5 clk = ~clk;

  ln_stat_accum #(.WIDTH(WIDTH), .VEC_LEN(VEC_LEN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_out    (sum_out),
    .sumsq_out  (sumsq_out)
`ifdef LN_STAT_ABSMAX_EN
    ,
    .absmax_out (absmax_out)
`endif
  );

  // Fifo model: read data appears the cycle after rd_en, zero otherwise.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= WIDTH'(fq.pop_front());
      pop_count <= pop_count + 1;
    end else begin
      fifo_dout <= '0;
    end
    while (push_req.size() > 0) fq.push_back(push_req.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // A read while the fifo is empty is always wrong.
  always @(negedge clk) begin
    if (rstn && fifo_empty) check_eq("rden_while_empty", fifo_rd_en, 0);
  end

  task automatic push(input int v);
    pushed.push_back(v);
    push_req.push_back(v);
  endtask

  // Reference: a vector is the next VEC_LEN values in write order.
  task automatic expect_vec(input int base, output longint s, output longint sq, output int am);
    s = 0; sq = 0; am = 0;
    for (int i = 0; i < VEC_LEN; i++) begin
      int v;
      int a;
      v = (base + i < pushed.size()) ? pushed[base + i] : 0;
      a = (v < 0) ? -v : v;
      s  += v;
      sq += v * v;
      if (a > am) am = a;
    end
  endtask

  task automatic do_vector(input string tag, input bit lat, input int hold, input bit poke);
    int base;
    int cyc;
    int am;
    longint s;
    longint sq;
    base  = pop_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!out_valid && cyc < 300) begin
      if (lat && cyc <= VEC_LEN + 1)
        check_eq($sformatf("%s_rden_c%0d", tag, cyc), fifo_rd_en, (cyc <= VEC_LEN));
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_done"}, out_valid, 1);
    if (lat) check_eq({tag, "_latency"}, cyc, VEC_LEN + 2);
    expect_vec(base, s, sq, am);
    for (int h = 0; h <= hold; h++) begin
      check_eq({tag, "_sum"}, sum_out, s);
      check_eq({tag, "_sumsq"}, sumsq_out, sq);
`ifdef LN_STAT_ABSMAX_EN
      check_eq({tag, "_absmax"}, absmax_out, am);
`endif
      check_eq({tag, "_valid"}, out_valid, 1);
      check_eq({tag, "_busy"}, busy, 1);
      check_eq({tag, "_pops"}, pop_count - base, VEC_LEN);
      if (h < hold) begin
        start = poke && (h % 3 == 1);
        @(negedge clk);
        start = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_valid_after"}, out_valid, 0);
    check_eq({tag, "_busy_after"}, busy, 0);
    check_eq({tag, "_sum_kept"}, sum_out, s);
  endtask

  initial begin
    int base;
    int cyc;
    byte b;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_sum", sum_out, 0);
    check_eq("rst_sumsq", sumsq_out, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rden", fifo_rd_en, 0);
`ifdef LN_STAT_ABSMAX_EN
    check_eq("rst_absmax", absmax_out, 0);
`endif
    rstn = 1'b1;
    @(negedge clk);

    // Preloaded fifo, latency trace
    push(1); push(2); push(3); push(4);
    repeat (2) @(negedge clk);
    do_vector("basic", 1'b1, 0, 1'b0);

    // Negative extremes
    repeat (4) push(-3);
    repeat (2) @(negedge clk);
    do_vector("neg3", 1'b1, 0, 1'b0);
    repeat (4) push(-128);
    repeat (2) @(negedge clk);
    do_vector("neg128", 1'b0, 0, 1'b0);

    // Empty stall after the second pop
    fork
      do_vector("stall", 1'b0, 0, 1'b0);
      begin
        push(17); push(-9);
        cyc = 0;
        while (pop_count < pushed.size() && cyc < 50) begin
          @(negedge clk);
          cyc++;
        end
        repeat (5) @(negedge clk);
        push(33); push(-70);
      end
    join

    // Consumer holds off; start pulses in DONE are ignored
    push(5); push(-7); push(100); push(-1);
    repeat (2) @(negedge clk);
    do_vector("hold", 1'b0, 10, 1'b1);

    // Reset mid-RUN after two pops
    push(50); push(60);
    repeat (2) @(negedge clk);
    base  = pop_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (pop_count - base < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("midrst_pops", pop_count - base, 2);
    rstn = 1'b0;
    #1;
    check_eq("midrst_sum", sum_out, 0);
    check_eq("midrst_sumsq", sumsq_out, 0);
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_rden", fifo_rd_en, 0);
`ifdef LN_STAT_ABSMAX_EN
    check_eq("midrst_absmax", absmax_out, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    push(11); push(-22); push(33); push(-44);
    repeat (2) @(negedge clk);
    do_vector("after_rst", 1'b0, 0, 1'b0);

    // Six preloaded, two back-to-back vectors
    push(1); push(-2); push(3); push(-4); push(5); push(-6);
    repeat (2) @(negedge clk);
    do_vector("b2b_a", 1'b0, 0, 1'b0);
    check_eq("b2b_left", fq.size(), 2);
    fork
      do_vector("b2b_b", 1'b0, 0, 1'b0);
      begin
        repeat (4) @(negedge clk);
        push(7); push(-8);
      end
    join

    // Random data, random write gaps and consumer delays
    for (int n = 0; n < 25; n++) begin
      fork
        do_vector($sformatf("rnd%0d", n), 1'b0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        begin
          for (int i = 0; i < VEC_LEN; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b = byte'($urandom);
            if ($urandom_range(0, 7) == 0) b = -128;
            push(int'(b));
          end
        end
      join
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
